mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between two requesters in the multi-cycle CPU: the instruction-fetch port (IF state) and the load/store port (MEM states).
- Arbitrates requests and registers the selected request onto the memory port.
- Waits for the memory's acknowledge with a watchdog timeout, then returns read data and a one-cycle ack to the winning requester.

Parameters:
- AW, 32, address width.
- DW, 32, data width (byte enables are DW/8 bits).
- MAX_D_STREAK, 4, maximum consecutive data grants allowed while a fetch is pending (range 1..15).
- TIMEOUT, 16, cycles m_req may stay high without m_ack before abort; 0 disables; must be <256.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- i_req  in  1  fetch request; held with i_addr stable until i_ack.
- i_addr  in  AW  fetch address.
- i_rdata  out  DW  fetch data, valid while i_ack=1.
- i_ack  out  1  one-cycle fetch completion pulse.
- i_err  out  1  qualifies i_ack: access timed out.
- d_req  in  1  load/store request; held with d_we, d_be, d_addr, d_wdata stable until d_ack.
- d_we  in  1  1 = store.
- d_be  in  DW/8  byte enables.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_rdata  out  DW  load data, valid while d_ack=1.
- d_ack  out  1  one-cycle data completion pulse.
- d_err  out  1  qualifies d_ack: access timed out.
- m_req  out  1  memory request; held until m_ack or abort.
- m_we  out  1  memory write enable.
- m_be  out  DW/8  memory byte enables.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_rdata  in  DW  memory read data, valid with m_ack.
- m_ack  in  1  memory completion, single-cycle pulse.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs are registered and 0; state = IDLE; streak and timeout counters = 0. RST asserted mid-access drops m_req immediately and issues no ack; the requester re-requests after reset.
- FSM states: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE, arbitration at the clock edge:
  - Only d_req set -> BUSY_D.
  - Only i_req set -> BUSY_I.
  - Both set -> BUSY_D, unless streak == MAX_D_STREAK, in which case BUSY_I.
- Leaving IDLE: the same edge registers m_req=1 and m_addr.
  - BUSY_I: m_we=0, m_be=all ones, m_wdata=0.
  - BUSY_D: m_we=d_we, m_be=d_be, m_wdata=d_wdata.
- Streak counter:
  - Increments, saturating, on a D grant with i_req=1.
  - Clears on a D grant with i_req=0.
  - Clears on any I grant.
- BUSY_x completion: if m_ack=1 -> DONE at the next edge.
  - That edge clears m_req, pulses x_ack=1, sets x_err=0, and captures m_rdata into x_rdata.
  - For stores, d_rdata is don't-care but is driven with the captured m_rdata.
- BUSY_x timeout (TIMEOUT != 0): the timeout counter clears on BUSY entry and increments each BUSY cycle with m_ack=0.
  - When the counter == TIMEOUT-1 and m_ack=0 -> DONE; m_req cleared, x_ack=1, x_err=1, x_rdata=0.
  - m_req is therefore high for exactly TIMEOUT cycles.
  - m_ack on that final cycle wins: the access completes normally.
- DONE: lasts one cycle; x_ack and x_err fall at the next edge. Requests are ignored in this cycle because the requester is still dropping req. The FSM always returns to IDLE.
- m_ack while in IDLE or DONE is ignored.
- Latency: request sampled at edge k; m_req high after k; memory acks in cycle j ≥ k+1; x_ack high in cycle j+1. Minimum request-to-ack is 2 cycles. Minimum issue interval is 3 cycles per access.
- Outputs to the non-granted requester stay 0.
- m_addr and m_wdata hold their last values when m_req=0.

Test Plan:
- Fetch only: i_req=1, i_addr=0x100, memory acks 2 cycles after m_req with m_rdata=0x00500093 -> m_we=0, m_be=4'b1111, i_ack high for 1 cycle with i_rdata=0x00500093, i_err=0, busy returns to 0.
- Store byte: d_req=1, d_we=1, d_be=4'b0001, d_addr=0x204, d_wdata=0xAB -> m_we=1, m_be=4'b0001, m_addr=0x204, m_wdata=0xAB; d_ack after m_ack; i_ack stays 0.
- Simultaneous requests: i_req and d_req both held, memory acks in 1 cycle -> grant order D,D,D,D,I,D,...; i_ack occurs after exactly 4 d_acks.
- Timeout: d_req=1, m_ack never asserted, TIMEOUT=16 -> m_req high exactly 16 cycles, then d_ack=1, d_err=1, d_rdata=0. Repeat with m_ack on the 16th cycle -> d_err=0 and data is returned.
- Reset mid-access: RST asserted while in BUSY_I -> m_req, i_ack and busy go to 0 asynchronously; after release with i_req held, a fresh access completes normally.
- Spurious ack: m_ack pulsed in IDLE with no request -> no ack output, state stays IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the instruction-fetch and load/store ports of the multi-cycle CPU onto
// one shared single-ported memory, with fetch-starvation guard and access watchdog.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic [DW-1:0]   i_rdata,
    output logic            i_ack,
    output logic            i_err,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic [DW-1:0]   d_rdata,
    output logic            d_ack,
    output logic            d_err,
    output logic            m_req,
    output logic            m_we,
    output logic [DW/8-1:0] m_be,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    input  logic [DW-1:0]   m_rdata,
    input  logic            m_ack,
    output logic            busy
);

    localparam int BW = DW / 8;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);
    localparam bit         TMO_EN     = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic [3:0] streak_q, streak_d;
    logic [7:0] tmo_q, tmo_d;
    logic pick_d_s, pick_i_s, finish_s, timeout_s;

    logic          m_req_q, m_req_d, m_we_q, m_we_d;
    logic [BW-1:0] m_be_q, m_be_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic          i_ack_q, i_ack_d, i_err_q, i_err_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic          d_ack_q, d_ack_d, d_err_q, d_err_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          busy_q, busy_d;

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: arbitration in IDLE, ack/watchdog completion in BUSY
    always_comb begin
        state_d   = state_q;
        pick_d_s  = 1'b0;
        pick_i_s  = 1'b0;
        finish_s  = 1'b0;
        timeout_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Data wins ties until it has starved a pending fetch MAX_D_STREAK times
                if (d_req && !(i_req && (streak_q == STREAK_MAX))) begin
                    pick_d_s = 1'b1;
                    state_d  = ST_BUSY_D;
                end else if (i_req) begin
                    pick_i_s = 1'b1;
                    state_d  = ST_BUSY_I;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (m_ack) begin
                    finish_s = 1'b1;
                    state_d  = ST_DONE;
                end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
                    finish_s  = 1'b1;
                    timeout_s = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and counter next values, all registered below
    always_comb begin
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_be_d    = m_be_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_ack_d   = 1'b0;
        i_err_d   = 1'b0;
        i_rdata_d = {DW{1'b0}};
        d_ack_d   = 1'b0;
        d_err_d   = 1'b0;
        d_rdata_d = {DW{1'b0}};
        busy_d    = (state_d != ST_IDLE);
        streak_d  = streak_q;
        tmo_d     = tmo_q;
        if (pick_d_s) begin
            m_req_d   = 1'b1;
            m_we_d    = d_we;
            m_be_d    = d_be;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            tmo_d     = 8'd0;
            if (i_req) begin
                streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;
            end else begin
                streak_d = 4'd0;
            end
        end else if (pick_i_s) begin
            m_req_d   = 1'b1;
            m_we_d    = 1'b0;
            m_be_d    = {BW{1'b1}};
            m_addr_d  = i_addr;
            m_wdata_d = {DW{1'b0}};
            tmo_d     = 8'd0;
            streak_d  = 4'd0;
        end else if (finish_s) begin
            m_req_d = 1'b0;
            if (state_q == ST_BUSY_I) begin
                i_ack_d   = 1'b1;
                i_err_d   = timeout_s;
                i_rdata_d = timeout_s ? {DW{1'b0}} : m_rdata;
            end else begin
                d_ack_d   = 1'b1;
                d_err_d   = timeout_s;
                d_rdata_d = timeout_s ? {DW{1'b0}} : m_rdata;
            end
        end else if ((state_q == ST_BUSY_I) || (state_q == ST_BUSY_D)) begin
            tmo_d = tmo_q + 8'd1;
        end else begin
            tmo_d = tmo_q;
        end
    end

    // Registered outputs and counters
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_be_q    <= {BW{1'b0}};
            m_addr_q  <= {AW{1'b0}};
            m_wdata_q <= {DW{1'b0}};
            i_ack_q   <= 1'b0;
            i_err_q   <= 1'b0;
            i_rdata_q <= {DW{1'b0}};
            d_ack_q   <= 1'b0;
            d_err_q   <= 1'b0;
            d_rdata_q <= {DW{1'b0}};
            busy_q    <= 1'b0;
            streak_q  <= 4'd0;
            tmo_q     <= 8'd0;
        end else begin
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_be_q    <= m_be_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_ack_q   <= i_ack_d;
            i_err_q   <= i_err_d;
            i_rdata_q <= i_rdata_d;
            d_ack_q   <= d_ack_d;
            d_err_q   <= d_err_d;
            d_rdata_q <= d_rdata_d;
            busy_q    <= busy_d;
            streak_q  <= streak_d;
            tmo_q     <= tmo_d;
        end
    end

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_be    = m_be_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_ack   = i_ack_q;
    assign i_err   = i_err_q;
    assign i_rdata = i_rdata_q;
    assign d_ack   = d_ack_q;
    assign d_err   = d_err_q;
    assign d_rdata = d_rdata_q;
    assign busy    = busy_q;

endmodule
